// File: rtl/bsch_pkg.sv
// Shared types and constants for the AHB burst scheduler.
// Size codes and burst encodings are common with the AHB master interface.
package bsch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } bsch_state_e;

    localparam logic [2:0] SIZE_B8  = 3'b000;
    localparam logic [2:0] SIZE_B16 = 3'b001;
    localparam logic [2:0] SIZE_B32 = 3'b010;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    localparam int BOUNDARY = 1024;

    // Unknown size codes fall back to word beats.
    function automatic logic [1:0] size_shift(input logic [2:0] size);
        case (size)
            SIZE_B8:  return 2'd0;
            SIZE_B16: return 2'd1;
            default:  return 2'd2;
        endcase
    endfunction

    function automatic logic addr_misaligned(input logic [1:0] addr_lo, input logic [1:0] shift);
        case (shift)
            2'd1:    return addr_lo[0];
            2'd2:    return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bsch_burst_len.sv
// Burst length calculator: min(MAX_BURST, remaining beats, beats left
// before the next 1 KB boundary). A zero remaining count yields zero.
module bsch_burst_len
    import bsch_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic [9:0]       addr_lo_i,
    input  logic [LEN_W-1:0] rem_i,
    input  logic [1:0]       shift_i,
    output logic [4:0]       len_o
);

    logic [10:0] to_bnd;
    logic [4:0]  len_rem;
    logic [4:0]  len_bnd;

    always_comb begin
        to_bnd  = (11'(BOUNDARY) - {1'b0, addr_lo_i}) >> shift_i;
        len_rem = (rem_i < LEN_W'(MAX_BURST)) ? rem_i[4:0] : 5'(MAX_BURST);
        len_bnd = (to_bnd < 11'(MAX_BURST)) ? to_bnd[4:0] : 5'(MAX_BURST);
        len_o   = (len_bnd < len_rem) ? len_bnd : len_rem;
    end

endmodule

// File: rtl/ahb_burst_sched.sv
// Job-level scheduler: splits one read and one write stream into AHB bursts
// and interleaves them by buffer occupancy, writes taking priority.
//
// state  | meaning
// IDLE   | waiting for a job START, alignment check on entry
// ARB    | pick an eligible burst (write first) or finish the job
// ISSUE  | IF_START pulse visible to the AHB interface
// WAIT   | burst in flight, advance pointer on BURST_DONE
// FINISH | IF_STOP pulse visible, DONE set
module ahb_burst_sched
    import bsch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic              I_BSCH_HCLK,
    input  logic              I_BSCH_HRESET_N,
    input  logic              I_BSCH_START,
    input  logic              I_BSCH_RESET,
    input  logic [ADDR_W-1:0] I_BSCH_SRC_ADDR,
    input  logic [ADDR_W-1:0] I_BSCH_DST_ADDR,
    input  logic [LEN_W-1:0]  I_BSCH_LEN,
    input  logic [2:0]        I_BSCH_SIZE,
    input  logic [4:0]        I_BSCH_IBUF_FREE,
    input  logic [4:0]        I_BSCH_OBUF_COUNT,
    input  logic              I_BSCH_BURST_DONE,
    output logic              O_BSCH_IF_START,
    output logic              O_BSCH_IF_STOP,
    output logic [ADDR_W-1:0] O_BSCH_IF_ADDR,
    output logic [4:0]        O_BSCH_IF_COUNT,
    output logic              O_BSCH_IF_WRITE,
    output logic              O_BSCH_BUSY,
    output logic              O_BSCH_DONE,
    output logic              O_BSCH_ERR
);

    bsch_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]  rd_rem_q, rd_rem_d;
    logic [LEN_W-1:0]  wr_rem_q, wr_rem_d;
    logic [1:0]        shift_q, shift_d;
    logic              if_start_q, if_start_d;
    logic              if_stop_q, if_stop_d;
    logic [ADDR_W-1:0] if_addr_q, if_addr_d;
    logic [4:0]        if_count_q, if_count_d;
    logic              if_write_q, if_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [4:0]        rd_len, wr_len;
    logic              rd_ok, wr_ok;
    logic [1:0]        start_shift;
    logic              start_bad;
    logic [ADDR_W-1:0] adv;

    bsch_burst_len #(.LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) u_rd_len (
        .addr_lo_i (rd_addr_q[9:0]),
        .rem_i     (rd_rem_q),
        .shift_i   (shift_q),
        .len_o     (rd_len)
    );

    bsch_burst_len #(.LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) u_wr_len (
        .addr_lo_i (wr_addr_q[9:0]),
        .rem_i     (wr_rem_q),
        .shift_i   (shift_q),
        .len_o     (wr_len)
    );

    assign rd_ok = (rd_rem_q != '0) && (I_BSCH_IBUF_FREE >= rd_len);
    assign wr_ok = (wr_rem_q != '0) && (I_BSCH_OBUF_COUNT >= wr_len);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        rd_rem_d    = rd_rem_q;
        wr_rem_d    = wr_rem_q;
        shift_d     = shift_q;
        if_start_d  = 1'b0;
        if_stop_d   = 1'b0;
        if_addr_d   = if_addr_q;
        if_count_d  = if_count_q;
        if_write_d  = if_write_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        start_shift = size_shift(I_BSCH_SIZE);
        start_bad   = addr_misaligned(I_BSCH_SRC_ADDR[1:0], start_shift)
                    | addr_misaligned(I_BSCH_DST_ADDR[1:0], start_shift);
        adv         = ADDR_W'(if_count_q) << shift_q;

        if (I_BSCH_RESET) begin
            // Soft reset keeps DONE/ERR so software can still read the outcome.
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            if_addr_d  = '0;
            if_count_d = '0;
            if_write_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (I_BSCH_START) begin
                        if (start_bad) begin
                            err_d = 1'b1;
                        end else begin
                            rd_addr_d = I_BSCH_SRC_ADDR;
                            wr_addr_d = I_BSCH_DST_ADDR;
                            rd_rem_d  = I_BSCH_LEN;
                            wr_rem_d  = I_BSCH_LEN;
                            shift_d   = start_shift;
                            done_d    = 1'b0;
                            err_d     = 1'b0;
                            busy_d    = 1'b1;
                            state_d   = ST_ARB;
                        end
                    end
                end
                ST_ARB: begin
                    // Stop/done are registered here so they appear together in FINISH.
                    if (rd_rem_q == '0 && wr_rem_q == '0) begin
                        if_stop_d = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_FINISH;
                    end else if (wr_ok) begin
                        if_addr_d  = wr_addr_q;
                        if_count_d = wr_len;
                        if_write_d = 1'b1;
                        if_start_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end else if (rd_ok) begin
                        if_addr_d  = rd_addr_q;
                        if_count_d = rd_len;
                        if_write_d = 1'b0;
                        if_start_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (I_BSCH_BURST_DONE) begin
                        if (if_write_q) begin
                            wr_addr_d = wr_addr_q + adv;
                            wr_rem_d  = wr_rem_q - LEN_W'(if_count_q);
                        end else begin
                            rd_addr_d = rd_addr_q + adv;
                            rd_rem_d  = rd_rem_q - LEN_W'(if_count_q);
                        end
                        state_d = ST_ARB;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I_BSCH_HCLK or negedge I_BSCH_HRESET_N) begin
        if (!I_BSCH_HRESET_N) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_rem_q   <= '0;
            wr_rem_q   <= '0;
            shift_q    <= '0;
            if_start_q <= 1'b0;
            if_stop_q  <= 1'b0;
            if_addr_q  <= '0;
            if_count_q <= '0;
            if_write_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_rem_q   <= rd_rem_d;
            wr_rem_q   <= wr_rem_d;
            shift_q    <= shift_d;
            if_start_q <= if_start_d;
            if_stop_q  <= if_stop_d;
            if_addr_q  <= if_addr_d;
            if_count_q <= if_count_d;
            if_write_q <= if_write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign O_BSCH_IF_START = if_start_q;
    assign O_BSCH_IF_STOP  = if_stop_q;
    assign O_BSCH_IF_ADDR  = if_addr_q;
    assign O_BSCH_IF_COUNT = if_count_q;
    assign O_BSCH_IF_WRITE = if_write_q;
    assign O_BSCH_BUSY     = busy_q;
    assign O_BSCH_DONE     = done_q;
    assign O_BSCH_ERR      = err_q;

endmodule

// File: tb/tb_ahb_burst_sched.sv
// Directed bench for ahb_burst_sched: inputs driven and outputs sampled on
// the falling clock edge, expected bursts computed by hand.
module tb_ahb_burst_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        soft_rst;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic [2:0]  size;
    logic [4:0]  ibuf_free;
    logic [4:0]  obuf_count;
    logic        burst_done;
    logic        if_start;
    logic        if_stop;
    logic [31:0] if_addr;
    logic [4:0]  if_count;
    logic        if_write;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_burst_sched #(.ADDR_W(32), .LEN_W(16), .MAX_BURST(16)) dut (
        .I_BSCH_HCLK       (clk),
        .I_BSCH_HRESET_N   (rst_n),
        .I_BSCH_START      (start),
        .I_BSCH_RESET      (soft_rst),
        .I_BSCH_SRC_ADDR   (src_addr),
        .I_BSCH_DST_ADDR   (dst_addr),
        .I_BSCH_LEN        (len),
        .I_BSCH_SIZE       (size),
        .I_BSCH_IBUF_FREE  (ibuf_free),
        .I_BSCH_OBUF_COUNT (obuf_count),
        .I_BSCH_BURST_DONE (burst_done),
        .O_BSCH_IF_START   (if_start),
        .O_BSCH_IF_STOP    (if_stop),
        .O_BSCH_IF_ADDR    (if_addr),
        .O_BSCH_IF_COUNT   (if_count),
        .O_BSCH_IF_WRITE   (if_write),
        .O_BSCH_BUSY       (busy),
        .O_BSCH_DONE       (done),
        .O_BSCH_ERR        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the negedge of cycle 1 (state ARB).
    task automatic start_job(input logic [2:0] sz, input logic [31:0] src,
                             input logic [31:0] dst, input logic [15:0] ln);
        size     = sz;
        src_addr = src;
        dst_addr = dst;
        len      = ln;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // BURST_DONE in cycle n; returns at the negedge of cycle n+2.
    task automatic done_pulse();
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_burst(input string tag, input logic [31:0] a,
                                input logic [4:0] c, input logic w);
        chk({tag, ".start"}, 32'(if_start), 32'd1);
        chk({tag, ".addr"},  if_addr, a);
        chk({tag, ".count"}, 32'(if_count), 32'(c));
        chk({tag, ".write"}, 32'(if_write), 32'(w));
    endtask

    task automatic expect_finish(input string tag);
        chk({tag, ".stop"},  32'(if_stop), 32'd1);
        chk({tag, ".done"},  32'(done), 32'd1);
        chk({tag, ".busy"},  32'(busy), 32'd0);
        chk({tag, ".start"}, 32'(if_start), 32'd0);
    endtask

    // Watches a few cycles for any unexpected start/stop pulse.
    task automatic expect_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | if_start | if_stop;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        soft_rst   = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        len        = '0;
        size       = 3'b010;
        ibuf_free  = '0;
        obuf_count = '0;
        burst_done = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst.flags", 32'({if_start, if_stop, if_write, busy, done, err}), 32'd0);
        chk("rst.addr",  if_addr, 32'd0);
        chk("rst.count", 32'(if_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word job: two reads, then two writes once the output buffer fills.
        ibuf_free = 5'd16;
        start_job(3'b010, 32'h1000, 32'h2000, 16'd32);
        chk("t1.busy", 32'(busy), 32'd1);
        @(negedge clk);
        expect_burst("t1.rd0", 32'h1000, 5'd16, 1'b0);
        @(negedge clk);
        chk("t1.pulse_once", 32'(if_start), 32'd0);
        chk("t1.addr_hold", if_addr, 32'h1000);
        done_pulse();
        expect_burst("t1.rd1", 32'h1040, 5'd16, 1'b0);
        obuf_count = 5'd16;
        @(negedge clk);
        done_pulse();
        expect_burst("t1.wr0", 32'h2000, 5'd16, 1'b1);
        @(negedge clk);
        done_pulse();
        expect_burst("t1.wr1", 32'h2040, 5'd16, 1'b1);
        @(negedge clk);
        done_pulse();
        expect_finish("t1.fin");
        @(negedge clk);
        chk("t1.stop_once", 32'(if_stop), 32'd0);
        chk("t1.done_sticky", 32'(done), 32'd1);

        // 1 KB boundary split on the read side.
        obuf_count = 5'd0;
        start_job(3'b010, 32'h13F0, 32'h3000, 16'd8);
        @(negedge clk);
        expect_burst("t2.rd0", 32'h13F0, 5'd4, 1'b0);
        @(negedge clk);
        done_pulse();
        expect_burst("t2.rd1", 32'h1400, 5'd4, 1'b0);
        obuf_count = 5'd8;
        @(negedge clk);
        done_pulse();
        expect_burst("t2.wr0", 32'h3000, 5'd8, 1'b1);
        @(negedge clk);
        done_pulse();
        expect_finish("t2.fin");
        @(negedge clk);

        // Both eligible: write goes first.
        obuf_count = 5'd16;
        start_job(3'b010, 32'h4000, 32'h5000, 16'd16);
        @(negedge clk);
        expect_burst("t3.wr0", 32'h5000, 5'd16, 1'b1);
        @(negedge clk);
        done_pulse();
        expect_burst("t3.rd0", 32'h4000, 5'd16, 1'b0);
        @(negedge clk);
        done_pulse();
        expect_finish("t3.fin");
        @(negedge clk);

        // Soft reset during WAIT.
        obuf_count = 5'd0;
        start_job(3'b010, 32'h1000, 32'h2000, 16'd16);
        @(negedge clk);
        expect_burst("t4.rd0", 32'h1000, 5'd16, 1'b0);
        @(negedge clk);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        chk("t4.busy",  32'(busy), 32'd0);
        chk("t4.stop",  32'(if_stop), 32'd0);
        chk("t4.done",  32'(done), 32'd0);
        chk("t4.addr",  if_addr, 32'd0);
        chk("t4.count", 32'(if_count), 32'd0);
        chk("t4.write", 32'(if_write), 32'd0);
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        expect_quiet("t4.quiet", 4);
        chk("t4.busy_after", 32'(busy), 32'd0);

        // Misaligned half-word source, then an aligned LEN=0 job.
        start_job(3'b001, 32'h1001, 32'h2000, 16'd4);
        chk("t5.err",  32'(err), 32'd1);
        chk("t5.busy", 32'(busy), 32'd0);
        expect_quiet("t5.quiet", 3);
        start_job(3'b001, 32'h1002, 32'h2000, 16'd0);
        chk("t5.err_clr", 32'(err), 32'd0);
        chk("t5.busy2",   32'(busy), 32'd1);
        @(negedge clk);
        expect_finish("t6.len0");
        @(negedge clk);

        // Half-word pointer advance.
        obuf_count = 5'd0;
        start_job(3'b001, 32'h1002, 32'h3000, 16'd20);
        @(negedge clk);
        expect_burst("t7.rd0", 32'h1002, 5'd16, 1'b0);
        @(negedge clk);
        done_pulse();
        expect_burst("t7.rd1", 32'h1022, 5'd4, 1'b0);
        obuf_count = 5'd16;
        @(negedge clk);
        done_pulse();
        expect_burst("t7.wr0", 32'h3000, 5'd16, 1'b1);
        @(negedge clk);
        done_pulse();
        expect_burst("t7.wr1", 32'h3020, 5'd4, 1'b1);
        @(negedge clk);
        done_pulse();
        expect_finish("t7.fin");
        @(negedge clk);

        // Byte beats across a 1 KB boundary.
        obuf_count = 5'd0;
        start_job(3'b000, 32'h03FE, 32'h0800, 16'd4);
        @(negedge clk);
        expect_burst("t8.rd0", 32'h03FE, 5'd2, 1'b0);
        @(negedge clk);
        done_pulse();
        expect_burst("t8.rd1", 32'h0400, 5'd2, 1'b0);
        obuf_count = 5'd16;
        @(negedge clk);
        done_pulse();
        expect_burst("t8.wr0", 32'h0800, 5'd4, 1'b1);
        @(negedge clk);
        done_pulse();
        expect_finish("t8.fin");
        @(negedge clk);

        // START while BUSY must not reload the job.
        ibuf_free  = 5'd0;
        obuf_count = 5'd0;
        start_job(3'b010, 32'h6000, 32'h7000, 16'd16);
        @(negedge clk);
        chk("t9.stall", 32'(if_start), 32'd0);
        start_job(3'b010, 32'h8000, 32'h9000, 16'd16);
        ibuf_free = 5'd16;
        @(negedge clk);
        expect_burst("t9.rd0", 32'h6000, 5'd16, 1'b0);
        obuf_count = 5'd16;
        @(negedge clk);
        done_pulse();
        expect_burst("t9.wr0", 32'h7000, 5'd16, 1'b1);
        @(negedge clk);
        done_pulse();
        expect_finish("t9.fin");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
